// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared defaults and FSM state type for the MAC processing element.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int c_pe_n     = 16;
    localparam int c_pe_acc_w = 40;
    localparam int c_pe_k_w   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } pe_state_t;

endpackage
`default_nettype wire

// File: rtl/booth_r4_comb.sv
`default_nettype none
// ============================================================================
// Module      : booth_r4_comb
// Description : Combinational radix-4 Booth multiplier, N/2 partial products.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_r4_comb
    import pe_pkg::*;
#(
    parameter int N = c_pe_n
) (
    input  logic signed [N-1:0]   i_a,
    input  logic signed [N-1:0]   i_b,
    output logic signed [2*N-1:0] o_p
);

    localparam int c_npp = N / 2;

    logic        [N:0]     w_bx;
    logic signed [2*N-1:0] w_a_ext;
    logic        [2*N-1:0] w_pp [c_npp];
    logic        [2*N-1:0] w_sum;

    assign w_bx    = {i_b, 1'b0};
    assign w_a_ext = (2*N)'(i_a);

    // Each recoded digit in {-2..+2} selects a multiple of a, weighted by 4^i.
    for (genvar gi = 0; gi < c_npp; gi++) begin : g_pp
        logic        [2:0]     w_grp;
        logic signed [2*N-1:0] w_mag;

        assign w_grp = w_bx[2*gi+2 -: 3];

        always_comb begin
            case (w_grp)
                3'b001, 3'b010: w_mag = w_a_ext;
                3'b011:         w_mag = w_a_ext <<< 1;
                3'b100:         w_mag = -(w_a_ext <<< 1);
                3'b101, 3'b110: w_mag = -w_a_ext;
                default:        w_mag = '0;
            endcase
        end

        assign w_pp[gi] = w_mag << (2*gi);
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < c_npp; i++) begin
            w_sum = w_sum + w_pp[i];
        end
    end

    assign o_p = w_sum;

endmodule
`default_nettype wire

// File: rtl/pe_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : pe_mac_accumulator
// Description : Output-stationary systolic PE: forwards operands, accumulates
//               Booth products into a dot product, drains via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_mac_accumulator
    import pe_pkg::*;
#(
    parameter int N     = c_pe_n,
    parameter int ACC_W = c_pe_acc_w,
    parameter int K_W   = c_pe_k_w
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [N-1:0]     a_in,
    input  logic signed [N-1:0]     b_in,
    input  logic                    in_valid,
    input  logic        [K_W-1:0]   k_len,
    output logic signed [N-1:0]     a_out,
    output logic signed [N-1:0]     b_out,
    output logic                    valid_out,
    output logic signed [ACC_W-1:0] result,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    ovf,
    output logic                    busy,
    output logic                    drop_err
);

    pe_state_t r_state;
    pe_state_t w_state_nxt;

    logic signed [N-1:0]     r_a_out;
    logic signed [N-1:0]     r_b_out;
    logic                    r_valid_out;
    logic        [K_W-1:0]   r_k;
    logic        [K_W-1:0]   r_cnt;
    logic signed [2*N-1:0]   w_prod;
    logic signed [2*N-1:0]   r_prod;
    logic                    r_prod_vld;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_ovf_add;
    logic                    r_ovf;
    logic                    r_drop_err;
    logic                    w_accept;
    logic                    w_first;
    logic                    w_drop;
    logic                    w_clear;

    booth_r4_comb #(.N(N)) u_booth (
        .i_a (a_in),
        .i_b (b_in),
        .o_p (w_prod)
    );

    assign w_prod_ext = ACC_W'(r_prod);
    assign w_sum      = r_acc + w_prod_ext;
    assign w_ovf_add  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                        (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_first     = 1'b0;
        w_drop      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (k_len != '0) begin
                        w_accept    = 1'b1;
                        w_first     = 1'b1;
                        w_state_nxt = (k_len == K_W'(1)) ? FLUSH : ACCUM;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (r_cnt + K_W'(1) == r_k) begin
                        w_state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                w_drop = in_valid;
                // The last product is in the stage-1 register until it is added.
                if (!r_prod_vld) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_drop = in_valid;
                if (result_ready) begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a_out     <= '0;
            r_b_out     <= '0;
            r_valid_out <= 1'b0;
            r_k         <= '0;
            r_cnt       <= '0;
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_drop_err  <= 1'b0;
        end else begin
            r_a_out     <= a_in;
            r_b_out     <= b_in;
            r_valid_out <= in_valid;
            r_prod_vld  <= w_accept;
            if (w_accept) begin
                r_prod <= w_prod;
            end
            if (w_first) begin
                r_k <= k_len;
            end
            if (w_clear) begin
                r_cnt <= '0;
            end else if (w_first) begin
                r_cnt <= K_W'(1);
            end else if (w_accept) begin
                r_cnt <= r_cnt + K_W'(1);
            end
            if (w_clear) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (r_prod_vld) begin
                r_acc <= w_sum;
                if (w_ovf_add) begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_drop) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    assign a_out        = r_a_out;
    assign b_out        = r_b_out;
    assign valid_out    = r_valid_out;
    assign result       = r_acc;
    assign result_valid = (r_state == DRAIN);
    assign ovf          = r_ovf;
    assign busy         = (r_state != IDLE);
    assign drop_err     = r_drop_err;

endmodule
`default_nettype wire
